// File: rtl/e2tt_pkg.sv
// Shared types and the EBCDIC-to-typewriter translation table for the console printer path.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
// Contents: printer command enum, sequencer state enum, NL/SP codes, ebcdic_to_tt().
package e2tt_pkg;

    typedef enum logic [2:0] {
        CMD_PRINT      = 3'd0,
        CMD_SHIFT_UP   = 3'd1,
        CMD_SHIFT_DOWN = 3'd2,
        CMD_SPACE      = 3'd3,
        CMD_NEWLINE    = 3'd4
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_SHIFT,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    localparam logic [7:0] E_NL = 8'h15;
    localparam logic [7:0] E_SP = 8'h40;

    typedef struct packed {
        logic       printable;
        logic       need_upper;
        logic       need_lower;
        logic [5:0] tt;
    } tt_info_t;

    // Letters map to tilt/rotate codes 0..25 regardless of case (the case is
    // a carriage property, not part of the code); digits 26..35; . , / 36..38.
    function automatic tt_info_t ebcdic_to_tt(input logic [7:0] b);
        tt_info_t   r;
        logic [3:0] zone;
        logic [3:0] dig;
        zone = b[7:4];
        dig  = b[3:0];
        r    = '0;
        case (zone)
            4'h8, 4'hC: if (dig >= 4'd1 && dig <= 4'd9) begin
                r.printable = 1'b1;
                r.tt        = 6'(dig) - 6'd1;
            end
            4'h9, 4'hD: if (dig >= 4'd1 && dig <= 4'd9) begin
                r.printable = 1'b1;
                r.tt        = 6'(dig) + 6'd8;
            end
            4'hA, 4'hE: if (dig >= 4'd2 && dig <= 4'd9) begin
                r.printable = 1'b1;
                r.tt        = 6'(dig) + 6'd16;
            end
            4'hF: if (dig <= 4'd9) begin
                r.printable = 1'b1;
                r.tt        = 6'(dig) + 6'd26;
            end
            default: ;
        endcase
        if (r.printable) begin
            r.need_lower = (zone == 4'h8) || (zone == 4'h9) || (zone == 4'hA);
            r.need_upper = (zone == 4'hC) || (zone == 4'hD) || (zone == 4'hE);
        end
        case (b)
            8'h4B: begin r.printable = 1'b1; r.tt = 6'd36; end
            8'h6B: begin r.printable = 1'b1; r.tt = 6'd37; end
            8'h61: begin r.printable = 1'b1; r.tt = 6'd38; end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/e2tt_fifo.sv
// Small synchronous FIFO holding EBCDIC bytes ahead of the print sequencer.
// Latency: 1 cycle push-to-visible; read data is the head entry, combinational.
// Backpressure: push ignored when full (even with a simultaneous pop); pop ignored when empty.
// Ports: clk, reset (sync, active-high), push/wdata, pop/rdata, full, empty, count.
module e2tt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/e2tt_seq.sv
// Sequenced EBCDIC-to-typewriter translator: FIFO, case tracking, shift insertion, print pacing.
// Latency: FIFO head to strobe 2 cycles; with a case shift, shift at +2 and char at +2+PRINT_CYCLES+1.
// Backpressure: o_data_ready = FIFO not full; strobes spaced >= PRINT_CYCLES+1 cycles apart.
// Ports: i_clk, i_reset (sync, active-high), i_data_reg/i_data_valid/o_data_ready input byte
//        handshake, o_tt_out/o_cmd/o_tt_strobe printer command, o_lower/upper_case_character
//        carriage case, o_invalid dropped-byte pulse, o_busy.
// Optional: define E2TT_AUTO_CR_EN for automatic NEWLINE when the column reaches COLUMNS.
module e2tt_seq
    import e2tt_pkg::*;
#(
    parameter int PRINT_CYCLES = 3,
    parameter int DEPTH        = 4,
    parameter int COLUMNS      = 126
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data_reg,
    input  logic       i_data_valid,
    output logic       o_data_ready,
    output logic [5:0] o_tt_out,
    output logic [2:0] o_cmd,
    output logic       o_tt_strobe,
    output logic       o_lower_case_character,
    output logic       o_upper_case_character,
    output logic       o_invalid,
    output logic       o_busy
);
    localparam int                CNT_W    = $clog2(PRINT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PRINT_CYCLES - 1);

    // FIFO
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [7:0]             fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_pop;

    // Sequencer state
    state_e            state_q;
    state_e            ret_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        hold_q;
    cmd_e              cmd_q;
    logic [5:0]        tt_q;
    logic              strobe_q;
    logic              invalid_q;
    logic              lc_q;
    logic              uc_q;

    // Decode of the held byte
    tt_info_t          info;
    cmd_e              hold_cmd;
    cmd_e              issue_cmd;
    logic              unprintable;
    logic              shift_needed;
    logic              shift_fire;
    logic              issue_fire;
    logic              cr_needed;
    logic              cr_retry;

    e2tt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .push  (i_data_valid),
        .wdata (i_data_reg),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    always_comb begin
        info     = ebcdic_to_tt(hold_q);
        hold_cmd = CMD_PRINT;
        if (hold_q == E_NL)      hold_cmd = CMD_NEWLINE;
        else if (hold_q == E_SP) hold_cmd = CMD_SPACE;
    end

    assign unprintable  = !info.printable && (hold_q != E_NL) && (hold_q != E_SP);
    assign shift_needed = (info.need_upper && lc_q) || (info.need_lower && uc_q);
    assign shift_fire   = (state_q == ST_DECODE) && !unprintable && shift_needed;
    // A command strobe is registered on entry to ISSUE, so it is visible while in ISSUE.
    assign issue_fire   = ((state_q == ST_DECODE) && !unprintable && !shift_needed) ||
                          ((state_q == ST_WAIT) && (cnt_q == '0) && (ret_q == ST_ISSUE));
    assign issue_cmd    = cr_needed ? CMD_NEWLINE : hold_cmd;

`ifdef E2TT_AUTO_CR_EN
    localparam int COL_W = $clog2(COLUMNS + 1);
    logic [COL_W-1:0] col_q;

    assign cr_needed = (hold_cmd != CMD_NEWLINE) && (col_q == COL_W'(COLUMNS));
    // An inserted NEWLINE leaves the held command still pending: go round ISSUE again.
    assign cr_retry  = (cmd_q == CMD_NEWLINE) && (hold_cmd != CMD_NEWLINE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            col_q <= '0;
        end else if (issue_fire) begin
            col_q <= (issue_cmd == CMD_NEWLINE) ? '0 : col_q + COL_W'(1);
        end
    end
`else
    logic unused_columns;
    assign unused_columns = (COLUMNS != 0);
    assign cr_needed      = 1'b0;
    assign cr_retry       = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            cmd_q     <= CMD_PRINT;
            tt_q      <= '0;
            strobe_q  <= 1'b0;
            invalid_q <= 1'b0;
            lc_q      <= 1'b1;
            uc_q      <= 1'b0;
        end else begin
            strobe_q  <= 1'b0;
            invalid_q <= 1'b0;

            if (issue_fire) begin
                strobe_q <= 1'b1;
                cmd_q    <= issue_cmd;
                if (issue_cmd == CMD_PRINT) tt_q <= info.tt;
            end

            // Case flags flip together with the shift strobe.
            if (shift_fire) begin
                strobe_q <= 1'b1;
                cmd_q    <= info.need_upper ? CMD_SHIFT_UP : CMD_SHIFT_DOWN;
                lc_q     <= !info.need_upper;
                uc_q     <= info.need_upper;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        hold_q  <= fifo_rdata;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (unprintable) begin
                        invalid_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (shift_needed) begin
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_SHIFT: begin
                    cnt_q   <= CNT_LOAD;
                    ret_q   <= ST_ISSUE;
                    state_q <= ST_WAIT;
                end
                ST_ISSUE: begin
                    cnt_q   <= CNT_LOAD;
                    ret_q   <= cr_retry ? ST_ISSUE : ST_IDLE;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) state_q <= ret_q;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_data_ready           = !fifo_full;
    assign o_tt_out               = tt_q;
    assign o_cmd                  = cmd_q;
    assign o_tt_strobe            = strobe_q;
    assign o_lower_case_character = lc_q;
    assign o_upper_case_character = uc_q;
    assign o_invalid              = invalid_q;
    assign o_busy                 = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_e2tt_seq.sv
// Bench for e2tt_seq: directed cases plus random bytes, scored against a character-level model.
// Latency: not applicable.
// Backpressure: driver holds each byte until o_data_ready is seen high.
module tb_e2tt_seq;
    localparam int PC    = 3;
    localparam int DEPTH = 4;
    localparam int COLS  = 4;

    localparam logic [2:0] C_PRINT = 3'd0;
    localparam logic [2:0] C_UP    = 3'd1;
    localparam logic [2:0] C_DOWN  = 3'd2;
    localparam logic [2:0] C_SPACE = 3'd3;
    localparam logic [2:0] C_NL    = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [5:0] tt;
    logic [2:0] cmd;
    logic       strobe;
    logic       lc;
    logic       uc;
    logic       invalid;
    logic       busy;

    e2tt_seq #(
        .PRINT_CYCLES (PC),
        .DEPTH        (DEPTH),
        .COLUMNS      (COLS)
    ) dut (
        .i_clk                  (clk),
        .i_reset                (reset),
        .i_data_reg             (data),
        .i_data_valid           (valid),
        .o_data_ready           (ready),
        .o_tt_out               (tt),
        .o_cmd                  (cmd),
        .o_tt_strobe            (strobe),
        .o_lower_case_character (lc),
        .o_upper_case_character (uc),
        .o_invalid              (invalid),
        .o_busy                 (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         inv;
        logic [2:0] cmd;
        logic [5:0] tt;
    } ev_t;

    ev_t exp_q[$];
    int  strobe_log[$];
    int  checks      = 0;
    int  errors      = 0;
    int  invalid_cnt = 0;
    int  last_strobe = -1000;
    bit  in_reset    = 1'b1;
    bit  saw_full    = 1'b0;

    // Reference model state: carriage case and column after all accepted bytes.
    bit  m_upper = 1'b0;
    int  m_col   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 0 unprintable, 1 caseless, 2 upper, 3 lower, 4 newline, 5 space
    function automatic void classify(input logic [7:0] b, output int kind, output int code);
        int rowbase[3]  = '{129, 145, 162};
        int rowlen[3]   = '{9, 9, 8};
        int rowstart[3] = '{0, 9, 18};
        int bi;
        bi   = int'(b);
        kind = 0;
        code = 0;
        if (bi == 21) kind = 4;
        else if (bi == 64) kind = 5;
        else begin
            for (int r = 0; r < 3; r++) begin
                if (bi >= rowbase[r] && bi < rowbase[r] + rowlen[r]) begin
                    kind = 3; code = rowstart[r] + bi - rowbase[r];
                end
                if (bi >= rowbase[r] + 64 && bi < rowbase[r] + 64 + rowlen[r]) begin
                    kind = 2; code = rowstart[r] + bi - rowbase[r] - 64;
                end
            end
            if (bi >= 240 && bi <= 249) begin kind = 1; code = 26 + bi - 240; end
            if (bi == 75)  begin kind = 1; code = 36; end
            if (bi == 107) begin kind = 1; code = 37; end
            if (bi == 97)  begin kind = 1; code = 38; end
        end
    endfunction

    function automatic void emit(input bit inv, input logic [2:0] c, input int code);
        ev_t e;
        e.inv = inv;
        e.cmd = c;
        e.tt  = 6'(code);
        exp_q.push_back(e);
    endfunction

    function automatic void model_issue(input logic [2:0] c, input int code);
`ifdef E2TT_AUTO_CR_EN
        if (c != C_NL && m_col == COLS) begin
            emit(1'b0, C_NL, 0);
            m_col = 0;
        end
`endif
        emit(1'b0, c, code);
        if (c == C_NL) m_col = 0;
        else           m_col++;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        int kind;
        int code;
        classify(b, kind, code);
        case (kind)
            0: emit(1'b1, C_PRINT, 0);
            4: model_issue(C_NL, 0);
            5: model_issue(C_SPACE, 0);
            default: begin
                if (kind == 2 && !m_upper) begin emit(1'b0, C_UP, 0);   m_upper = 1'b1; end
                if (kind == 3 &&  m_upper) begin emit(1'b0, C_DOWN, 0); m_upper = 1'b0; end
                model_issue(C_PRINT, code);
            end
        endcase
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        ev_t e;
        if (!in_reset) begin
            check("case_onehot", 32'(lc ^ uc), 32'd1);
            if (strobe) begin
                strobe_log.push_back(cyc);
                check("strobe_spacing", 32'(cyc - last_strobe >= PC + 1), 32'd1);
                last_strobe = cyc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got cmd %0d, expected no strobe", cmd);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_not_invalid", 32'(e.inv), 32'd0);
                    check("cmd", 32'(cmd), 32'(e.cmd));
                    if (e.cmd == C_PRINT) check("tt_out", 32'(tt), 32'(e.tt));
                    if (e.cmd == C_UP)    check("uc_with_shift_up", 32'(uc), 32'd1);
                    if (e.cmd == C_DOWN)  check("lc_with_shift_down", 32'(lc), 32'd1);
                end
            end
            if (invalid) begin
                invalid_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_invalid: got pulse, expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("invalid_expected", 32'(e.inv), 32'd1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, output int pcyc);
        int w = 0;
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        while (!ready && w < 500) begin
            saw_full = 1'b1;
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready stayed 0, expected 1");
            pcyc = -1;
        end else begin
            pcyc = cyc;
            model_push(b);
            @(posedge clk);
            #1 valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((exp_q.size() != 0 || busy) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check({name, "_drained"}, 32'(w < 3000), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tt"},      32'(tt),      32'd0);
        check({pfx, "_cmd"},     32'(cmd),     32'd0);
        check({pfx, "_strobe"},  32'(strobe),  32'd0);
        check({pfx, "_lc"},      32'(lc),      32'd1);
        check({pfx, "_uc"},      32'(uc),      32'd0);
        check({pfx, "_invalid"}, 32'(invalid), 32'd0);
        check({pfx, "_ready"},   32'(ready),   32'd1);
        check({pfx, "_busy"},    32'(busy),    32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p;
        int w;
        int n;
        logic [7:0] b;
        reset = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        in_reset = 1'b0;

        // Caseless digit: single PRINT, 3 cycles after push (2 after pop).
        strobe_log.delete();
        send(8'hF0, p);
        drain("digit");
        check("digit_strobes", 32'(strobe_log.size()), 32'd1);
        if (strobe_log.size() >= 1) check("digit_latency", 32'(strobe_log[0] - p), 32'd3);
        check("digit_lc", 32'(lc), 32'd1);

        // Upper then lower letter: shift inserted each time.
        strobe_log.delete();
        send(8'hC1, p);
        drain("upper");
        check("upper_strobes", 32'(strobe_log.size()), 32'd2);
        if (strobe_log.size() >= 2) begin
            check("upper_shift_latency", 32'(strobe_log[0] - p), 32'd3);
            check("upper_char_gap", 32'(strobe_log[1] - strobe_log[0]), 32'(PC + 1));
        end
        check("upper_uc", 32'(uc), 32'd1);
        strobe_log.delete();
        send(8'h81, p);
        drain("lower");
        check("lower_strobes", 32'(strobe_log.size()), 32'd2);
        check("lower_lc", 32'(lc), 32'd1);

        // Newline and space do not touch case.
        strobe_log.delete();
        send(8'h15, p);
        send(8'h40, p);
        drain("nl_sp");
        check("nl_sp_strobes", 32'(strobe_log.size()), 32'd2);
        check("nl_sp_lc", 32'(lc), 32'd1);

        // Burst past FIFO depth.
        strobe_log.delete();
        saw_full = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) send(8'hF1 + 8'(i), p);
        drain("burst");
        check("burst_saw_full", 32'(saw_full), 32'd1);
        check("burst_strobes", 32'(strobe_log.size()), 32'(DEPTH + 2));

        // Unprintable byte dropped, next one processed.
        strobe_log.delete();
        n = invalid_cnt;
        send(8'h00, p);
        send(8'hF2, p);
        drain("invalid");
        check("invalid_pulses", 32'(invalid_cnt - n), 32'd1);
        check("invalid_strobes", 32'(strobe_log.size()), 32'd1);

        // Reset while waiting after SHIFT_UP.
        strobe_log.delete();
        send(8'hC2, p);
        w = 0;
        while (strobe_log.size() == 0 && w < 100) begin @(negedge clk); w++; end
        check("reset_shift_seen", 32'(strobe_log.size()), 32'd1);
        @(negedge clk);
        in_reset = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        m_upper = 1'b0;
        m_col   = 0;
        reset   = 1'b0;
        @(negedge clk);
        last_strobe = -1000;
        in_reset    = 1'b0;
        strobe_log.delete();
        send(8'hC2, p);
        drain("after_reset");
        check("after_reset_strobes", 32'(strobe_log.size()), 32'd2);

        // Column run: with auto-CR a NEWLINE appears before the fifth PRINT.
        strobe_log.delete();
        send(8'h15, p);
        for (int i = 0; i < 5; i++) send(8'hF0, p);
        drain("columns");
`ifdef E2TT_AUTO_CR_EN
        check("columns_strobes", 32'(strobe_log.size()), 32'd7);
`else
        check("columns_strobes", 32'(strobe_log.size()), 32'd6);
`endif

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'($urandom_range(0, 255));
                1:       b = 8'h15;
                2:       b = 8'h40;
                3, 4, 5: b = 8'h81 + 8'($urandom_range(0, 8)) + 8'(16 * $urandom_range(0, 1));
                6, 7, 8: b = 8'hC1 + 8'($urandom_range(0, 8)) + 8'(16 * $urandom_range(0, 1));
                default: b = 8'hF0 + 8'($urandom_range(0, 9));
            endcase
            send(b, p);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
